// File: rtl/gf180mcu_fd_sc_mcu7t5v0__arbrr2_1.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_fd_sc_mcu7t5v0__arbrr2_1
// Brief    : Two-way round-robin arbiter with registered grants driving a
//            shared AOI22 output path. Optional grant lock with a 7-cycle
//            starvation limit when GF180MCU_FD_SC_MCU7T5V0_ARBRR2_LOCK_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu7t5v0__arbrr2_1 (
    input  logic CLK,
    input  logic RN,
    input  logic REQA,
    input  logic REQB,
    input  logic DA,
    input  logic DB,
    input  logic LOCK,
    output logic GNTA,
    output logic GNTB,
    output logic ZN,
    output logic BUSY,
    inout  wire  VDD,
    inout  wire  VSS
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GA   = 2'd1,
        GB   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   ptr_q, ptr_d;

`ifdef GF180MCU_FD_SC_MCU7T5V0_ARBRR2_LOCK_EN
    logic [2:0] hcnt_q, hcnt_d;
    logic       hold;
`endif

    // Supplies carry no logic; LOCK is only consumed when the lock feature is built.
    wire unused_ok = &{1'b0, VDD, VSS, LOCK};

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0_ARBRR2_LOCK_EN
            hcnt_q  <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
`ifdef GF180MCU_FD_SC_MCU7T5V0_ARBRR2_LOCK_EN
            hcnt_q  <= hcnt_d;
`endif
        end
    end

    always_comb begin
        state_d = IDLE;
        ptr_d   = ptr_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0_ARBRR2_LOCK_EN
        hcnt_d  = 3'd0;
        // Lock holds only while the grantee still requests, and yields once
        // the counter is exhausted and the other side is waiting.
        hold    = LOCK &&
                  (((state_q == GA) && REQA && !((hcnt_q == 3'd7) && REQB)) ||
                   ((state_q == GB) && REQB && !((hcnt_q == 3'd7) && REQA)));
        if (hold) begin
            state_d = state_q;
            hcnt_d  = (hcnt_q == 3'd7) ? 3'd7 : hcnt_q + 3'd1;
        end else
`endif
        if (REQA && REQB) begin
            state_d = ptr_q ? GB : GA;
        end else if (REQA) begin
            state_d = GA;
        end else if (REQB) begin
            state_d = GB;
        end else begin
            state_d = IDLE;
        end

        // Any issued grant hands tie priority to the other requester.
        if (state_d == GA) begin
            ptr_d = 1'b1;
        end else if (state_d == GB) begin
            ptr_d = 1'b0;
        end
    end

    assign GNTA = (state_q == GA);
    assign GNTB = (state_q == GB);
    assign BUSY = GNTA | GNTB;
    assign ZN   = ~((GNTA & DA) | (GNTB & DB));

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__arbrr2_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf180mcu_fd_sc_mcu7t5v0__arbrr2_1
// Brief    : Directed self-checking bench for the two-way round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gf180mcu_fd_sc_mcu7t5v0__arbrr2_1;

    logic CLK = 1'b0;
    logic RN, REQA, REQB, DA, DB, LOCK;
    logic GNTA, GNTB, ZN, BUSY;
    wire  VDD;
    wire  VSS;
    assign VDD = 1'b1;
    assign VSS = 1'b0;

    int checks   = 0;
    int failures = 0;

    gf180mcu_fd_sc_mcu7t5v0__arbrr2_1 dut (
        .CLK  (CLK),
        .RN   (RN),
        .REQA (REQA),
        .REQB (REQB),
        .DA   (DA),
        .DB   (DB),
        .LOCK (LOCK),
        .GNTA (GNTA),
        .GNTB (GNTB),
        .ZN   (ZN),
        .BUSY (BUSY),
        .VDD  (VDD),
        .VSS  (VSS)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge so outputs are sampled away from it.
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        RN = 1'b0; REQA = 1'b1; REQB = 1'b1; DA = 1'b1; DB = 1'b1; LOCK = 1'b0;
        tick;
        tick;
        chk("rst_gnt",  {6'd0, GNTA, GNTB}, 8'b00);
        chk("rst_zn",   {7'd0, ZN},   8'd1);
        chk("rst_busy", {7'd0, BUSY}, 8'd0);

        // Release between edges; first edge with RN=1 grants A (PTR=0).
        RN = 1'b1;
        tick;
        chk("first_gnt", {6'd0, GNTA, GNTB}, 8'b10);
        chk("first_busy", {7'd0, BUSY}, 8'd1);
        for (int i = 1; i < 6; i++) begin
            tick;
            chk($sformatf("alt%0d", i), {6'd0, GNTA, GNTB}, (i % 2) ? 8'b01 : 8'b10);
        end

        // B holds the grant: ZN follows DB combinationally, DA is masked.
        DA = 1'b0; DB = 1'b1; #1;
        chk("zn_db1", {7'd0, ZN}, 8'd0);
        DB = 1'b0; #1;
        chk("zn_db0", {7'd0, ZN}, 8'd1);
        DA = 1'b1; #1;
        chk("zn_da_masked", {7'd0, ZN}, 8'd1);

        // Asynchronous reset mid-grant.
        DB = 1'b1; #1;
        RN = 1'b0; #1;
        chk("async_gnt", {6'd0, GNTA, GNTB}, 8'b00);
        chk("async_zn",  {7'd0, ZN}, 8'd1);
        RN = 1'b1;
        tick;
        chk("async_ptr0", {6'd0, GNTA, GNTB}, 8'b10);

        // Single requester from IDLE.
        REQA = 1'b0; REQB = 1'b0;
        tick;
        chk("idle_gnt",  {6'd0, GNTA, GNTB}, 8'b00);
        chk("idle_busy", {7'd0, BUSY}, 8'd0);
        REQB = 1'b1;
        tick;
        chk("single_b", {6'd0, GNTA, GNTB}, 8'b01);
        REQB = 1'b0;
        tick;
        chk("single_drop", {6'd0, GNTA, GNTB}, 8'b00);
        chk("single_busy", {7'd0, BUSY}, 8'd0);

        // Dropping REQ releases the grant even under LOCK.
        REQA = 1'b1;
        tick;
        chk("lockdrop_ga", {6'd0, GNTA, GNTB}, 8'b10);
        REQA = 1'b0; LOCK = 1'b1;
        tick;
        chk("lockdrop_idle", {6'd0, GNTA, GNTB}, 8'b00);

        // Lock window: A granted alone, then both request with LOCK high.
        LOCK = 1'b0; REQA = 1'b1;
        tick;
        chk("lock_start", {6'd0, GNTA, GNTB}, 8'b10);
        REQB = 1'b1; LOCK = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick;
`ifdef GF180MCU_FD_SC_MCU7T5V0_ARBRR2_LOCK_EN
            chk($sformatf("lock%0d", i), {6'd0, GNTA, GNTB}, (i < 8) ? 8'b10 : 8'b01);
`else
            chk($sformatf("lock%0d", i), {6'd0, GNTA, GNTB}, (i % 2) ? 8'b01 : 8'b10);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gf180mcu_fd_sc_mcu7t5v0__arbrr2_1.md
GF180MCU_FD_SC_MCU7T5V0__ARBRR2_1 -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__arbrr2_1

Interface
REQ-001 The block SHALL have a single clock input: CLK, input, 1 bit, all state updates on its rising edge.
REQ-002 The block SHALL have an asynchronous, active-low reset input: RN, input, 1 bit.
REQ-003 The block SHALL have input REQA, 1 bit: requester A asks for the shared output path.
REQ-004 The block SHALL have input REQB, 1 bit: requester B asks for the shared output path.
REQ-005 The block SHALL have input DA, 1 bit: data of requester A.
REQ-006 The block SHALL have input DB, 1 bit: data of requester B.
REQ-007 The block SHALL have input LOCK, 1 bit: current grantee asks to keep its grant.
REQ-008 The block SHALL have output GNTA, 1 bit: registered grant to A.
REQ-009 The block SHALL have output GNTB, 1 bit: registered grant to B.
REQ-010 The block SHALL have output ZN, 1 bit: shared AOI22 path, ZN = !((GNTA & DA) | (GNTB & DB)).
REQ-011 The block SHALL have output BUSY, 1 bit: GNTA | GNTB.
REQ-012 The block SHALL have VDD and VSS, inout, 1 bit each: supply pins, no functional effect.

Function
REQ-013 The block SHALL implement states IDLE (no grant), GA (GNTA=1) and GB (GNTB=1); GNTA and GNTB SHALL be one-hot or both 0.
REQ-014 The block SHALL hold a 1-bit priority pointer PTR; PTR=0 means A wins a tie, PTR=1 means B wins a tie.
REQ-015 The block SHALL re-arbitrate on every rising CLK edge; grants change one cycle after the request change that causes them.
REQ-016 When only one request is high, the block SHALL grant that requester on the next edge.
REQ-017 When both requests are high and no lock is in force, the block SHALL grant per PTR.
REQ-018 When neither request is high and no lock is in force, the block SHALL go to IDLE.
REQ-019 On every edge that issues a grant, PTR SHALL be set to point at the other requester.
REQ-020 With both requests held high and LOCK=0, the grant SHALL alternate A,B,A,B,... each cycle.
REQ-021 A grant SHALL drop on the edge after its requester drops REQ, even if LOCK=1.
REQ-022 ZN SHALL be combinational from GNTA/GNTB/DA/DB; in IDLE, ZN SHALL be 1.

Reset
REQ-023 When RN=0, the block SHALL asynchronously force state IDLE, GNTA=0, GNTB=0, BUSY=0, ZN=1, PTR=0 and hold counter HCNT=0.
REQ-024 After RN rises, the first arbitration SHALL occur on the first rising CLK edge with RN=1.
REQ-025 A reset asserted mid-grant SHALL drop the grant immediately, without waiting for CLK.

Configuration
REQ-026 The block SHALL support the macro GF180MCU_FD_SC_MCU7T5V0_ARBRR2_LOCK_EN.
REQ-027 With the macro defined, LOCK=1 SHALL hold the current grant while its requester keeps REQ high. A 3-bit counter HCNT SHALL count the locked cycles.
REQ-028 With the macro defined, when HCNT reaches 7 and the other requester is requesting, the block SHALL force rotation and clear HCNT.
REQ-029 With the macro defined, HCNT SHALL clear on any grant change or on IDLE.
REQ-030 With the macro undefined, the LOCK port SHALL exist but be ignored, and no HCNT logic SHALL be present.

Verification
REQ-031 The bench SHALL cover reset: RN=0 with REQA=REQB=1 -> GNTA=GNTB=0, ZN=1; after RN=1, first edge -> GNTA=1 (PTR=0).
REQ-032 The bench SHALL cover alternation: REQA=REQB=1, LOCK=0 for 6 edges -> grants A,B,A,B,A,B.
REQ-033 The bench SHALL cover datapath: GNTB=1, DB=1, DA=0 -> ZN=0; DB=0 -> ZN=1 in the same cycle.
REQ-034 The bench SHALL cover single request: only REQB=1 from IDLE -> GNTB=1 next edge; REQB=0 -> IDLE next edge, BUSY=0.
REQ-035 The bench SHALL cover lock with the macro defined: GNTA, LOCK=1, REQA=REQB=1 -> A held for 8 cycles, then GNTB=1; without the macro -> alternation as in REQ-032.
REQ-036 The bench SHALL cover async reset mid-grant: RN pulsed low between edges while GNTB=1 -> GNTB=0 immediately, PTR=0.
